// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: freeze, flush and hazard bubbles, valid tracking.
// Optional perf counters (bubble_cnt, flush_cnt) enabled by IDEX_PERF_CNT_EN.
module id_ex_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  hazard,
  input  logic                  valid_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  wb_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [3:0]            status_in,
  output logic                  valid_out,
  output logic [3:0]            exe_cmd_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  wb_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     val_rn_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic                  imm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           signed_imm24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
`ifdef IDEX_PERF_CNT_EN
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic [3:0]            status_out
);

  typedef struct packed {
    logic                  valid;
    logic [3:0]            exe_cmd;
    logic                  mem_read;
    logic                  mem_write;
    logic                  wb_en;
    logic                  b;
    logic                  s;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val_rn;
    logic [DATA_W-1:0]     val_rm;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm24;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [3:0]            status;
  } id_ex_t;

  id_ex_t r;
  id_ex_t cap;

  // Capture word; side-effecting control bits are gated off for invalid slots.
  always_comb begin
    cap               = '0;
    cap.valid         = valid_in;
    cap.exe_cmd       = exe_cmd_in;
    cap.mem_read      = mem_read_in & valid_in;
    cap.mem_write     = mem_write_in & valid_in;
    cap.wb_en         = wb_en_in & valid_in;
    cap.b             = b_in & valid_in;
    cap.s             = s_in & valid_in;
    cap.pc            = pc_in;
    cap.val_rn        = val_rn_in;
    cap.val_rm        = val_rm_in;
    cap.imm           = imm_in;
    cap.shift_operand = shift_operand_in;
    cap.signed_imm24  = signed_imm24_in;
    cap.dest          = dest_in;
    cap.src1          = src1_in;
    cap.src2          = src2_in;
    cap.status        = status_in;
  end

  // Stage register: flush beats freeze, freeze beats hazard; bubbles are all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
    end else if (flush) begin
      r <= '0;
    end else if (!freeze) begin
      if (hazard) r <= '0;
      else        r <= cap;
    end
  end

  assign valid_out         = r.valid;
  assign exe_cmd_out       = r.exe_cmd;
  assign mem_read_out      = r.mem_read;
  assign mem_write_out     = r.mem_write;
  assign wb_en_out         = r.wb_en;
  assign b_out             = r.b;
  assign s_out             = r.s;
  assign pc_out            = r.pc;
  assign val_rn_out        = r.val_rn;
  assign val_rm_out        = r.val_rm;
  assign imm_out           = r.imm;
  assign shift_operand_out = r.shift_operand;
  assign signed_imm24_out  = r.signed_imm24;
  assign dest_out          = r.dest;
  assign src1_out          = r.src1;
  assign src2_out          = r.src2;
  assign status_out        = r.status;

`ifdef IDEX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating counters: hazard bubbles only count when actually loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (flush && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
      if (!flush && !freeze && hazard && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
